// File: rtl/bus_arbiter_if.sv
// Two-master / three-slave arbitration bus: requests, addresses and slave readiness in; grants and status out.
interface bus_arbiter_if;
    logic        m1_request;
    logic        m2_request;
    logic [13:0] m1_addr;
    logic [13:0] m2_addr;
    logic        m1_burst;
    logic        m2_burst;
    logic [2:0]  s_ready;
    logic        m1_grant;
    logic        m2_grant;
    logic [2:0]  slave_sel;
    logic        m1_addr_err;
    logic        m2_addr_err;
    logic        bus_busy;
    logic [1:0]  arb_state;

    modport slave (
        input  m1_request, m2_request, m1_addr, m2_addr, m1_burst, m2_burst, s_ready,
        output m1_grant, m2_grant, slave_sel, m1_addr_err, m2_addr_err, bus_busy, arb_state
    );

    modport master (
        output m1_request, m2_request, m1_addr, m2_addr, m1_burst, m2_burst, s_ready,
        input  m1_grant, m2_grant, slave_sel, m1_addr_err, m2_addr_err, bus_busy, arb_state
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master fair arbiter with tenure limits and slave decode; grant 1 cycle after a valid request.
// Requests to a non-ready slave wait in IDLE; every grant is followed by a 1-cycle TURN gap.
module bus_arbiter #(
    parameter int unsigned TENURE_MAX       = 8,
    parameter int unsigned BURST_TENURE_MAX = 32
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2,
        TURN   = 2'd3
    } state_t;

    localparam logic [5:0] LIM_SINGLE = 6'(TENURE_MAX);
    localparam logic [5:0] LIM_BURST  = 6'(BURST_TENURE_MAX);

    state_t     r_state;
    logic       r_last_m2;
    logic [5:0] r_cnt;
    logic [5:0] r_limit;
    logic       r_m1_grant;
    logic       r_m2_grant;
    logic [2:0] r_sel;
    logic       r_m1_err;
    logic       r_m2_err;
    logic       r_busy;

    logic [2:0] w_m1_sel;
    logic [2:0] w_m2_sel;
    logic       w_m1_unmapped;
    logic       w_m2_unmapped;
    logic       w_m1_vld;
    logic       w_m2_vld;
    logic       w_pick_m1;
    logic       w_pick_m2;
    logic       w_own_req;
    logic       w_other_req;
    logic       w_preempt;

    function automatic logic [2:0] decode(input logic [1:0] region);
        case (region)
            2'b00:   decode = 3'b001;
            2'b01:   decode = 3'b010;
            2'b10:   decode = 3'b100;
            default: decode = 3'b000;
        endcase
    endfunction

    assign w_m1_sel      = decode(bus.m1_addr[13:12]);
    assign w_m2_sel      = decode(bus.m2_addr[13:12]);
    assign w_m1_unmapped = (w_m1_sel == 3'b000);
    assign w_m2_unmapped = (w_m2_sel == 3'b000);
    assign w_m1_vld      = bus.m1_request && (|(w_m1_sel & bus.s_ready));
    assign w_m2_vld      = bus.m2_request && (|(w_m2_sel & bus.s_ready));

    // On a tie the master not served last wins.
    assign w_pick_m1 = w_m1_vld && (!w_m2_vld || r_last_m2);
    assign w_pick_m2 = w_m2_vld && !w_pick_m1;

    assign w_own_req   = (r_state == GRANT2) ? bus.m2_request : bus.m1_request;
    assign w_other_req = (r_state == GRANT2) ? bus.m1_request : bus.m2_request;
    // ">=" keeps a saturated owner preemptible by a competitor that arrives late.
    assign w_preempt   = w_other_req && (({1'b0, r_cnt} + 7'd1) >= {1'b0, r_limit});

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last_m2  <= 1'b1;
            r_cnt      <= 6'd0;
            r_limit    <= 6'd0;
            r_m1_grant <= 1'b0;
            r_m2_grant <= 1'b0;
            r_sel      <= 3'b000;
            r_m1_err   <= 1'b0;
            r_m2_err   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_m1_err <= 1'b0;
            r_m2_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Toggling against the previous value repeats the pulse every other cycle.
                    r_m1_err <= bus.m1_request && w_m1_unmapped && !r_m1_err;
                    r_m2_err <= bus.m2_request && w_m2_unmapped && !r_m2_err;
                    if (w_pick_m1) begin
                        r_state    <= GRANT1;
                        r_m1_grant <= 1'b1;
                        r_sel      <= w_m1_sel;
                        r_busy     <= 1'b1;
                        r_cnt      <= 6'd0;
                        r_limit    <= bus.m1_burst ? LIM_BURST : LIM_SINGLE;
                    end else if (w_pick_m2) begin
                        r_state    <= GRANT2;
                        r_m2_grant <= 1'b1;
                        r_sel      <= w_m2_sel;
                        r_busy     <= 1'b1;
                        r_cnt      <= 6'd0;
                        r_limit    <= bus.m2_burst ? LIM_BURST : LIM_SINGLE;
                    end
                end
                GRANT1, GRANT2: begin
                    if (r_cnt != r_limit) begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                    if (!w_own_req || w_preempt) begin
                        r_state    <= TURN;
                        r_m1_grant <= 1'b0;
                        r_m2_grant <= 1'b0;
                        r_sel      <= 3'b000;
                        r_busy     <= 1'b0;
                        r_last_m2  <= (r_state == GRANT2);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m1_grant    = r_m1_grant;
    assign bus.m2_grant    = r_m2_grant;
    assign bus.slave_sel   = r_sel;
    assign bus.m1_addr_err = r_m1_err;
    assign bus.m2_addr_err = r_m2_err;
    assign bus.bus_busy    = r_busy;
    assign bus.arb_state   = r_state;
endmodule
